// File: rtl/vm_pkg.sv
// Shared state type and coin values for the multi-product vending controller.
package vm_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} vm_state_e;

   localparam int QUARTER = 25;
   localparam int DOLLAR  = 100;

endpackage

// File: rtl/vm_stock_bank.sv
// Per-product stock counters with decrement, global refill and registered sold-out flags.
module vm_stock_bank
   import vm_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int STOCK_INIT   = 3,
   localparam int SEL_W = $clog2(NUM_PRODUCTS),
   localparam int STK_W = $clog2(STOCK_INIT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dec_i,
   input  logic [SEL_W-1:0]        dec_id_i,
   input  logic                    refill_i,
   output logic [NUM_PRODUCTS-1:0] sold_out_o
);
   localparam logic [STK_W-1:0] INIT_C = STK_W'(STOCK_INIT);

   logic [STK_W-1:0]        stock_q [NUM_PRODUCTS];
   logic [STK_W-1:0]        stock_d [NUM_PRODUCTS];
   logic [NUM_PRODUCTS-1:0] sold_out_q, sold_out_d;

   // Refill wins over a same-cycle decrement; sold_out tracks the next stock value.
   always_comb begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         stock_d[i] = stock_q[i];
         if (refill_i) begin
            stock_d[i] = INIT_C;
         end else if (dec_i && (dec_id_i == SEL_W'(i)) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - STK_W'(1);
         end
         sold_out_d[i] = (stock_d[i] == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= INIT_C;
         sold_out_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= stock_d[i];
         sold_out_q <= sold_out_d;
      end
   end

   assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, vend decision, change return.
//   state    | meaning
//   IDLE     | no credit, accepting coins and requests
//   COLLECT  | credit > 0, accepting coins and requests
//   DISPENSE | one cycle: item released, price deducted
//   CHANGE   | one quarter returned per cycle until credit is 0
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int PRICE        = 75,
   parameter int MAX_CREDIT   = 200,
   parameter int STOCK_INIT   = 3,
   localparam int SEL_W    = $clog2(NUM_PRODUCTS),
   localparam int CREDIT_W = $clog2(MAX_CREDIT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Q_in,
   input  logic                    D_in,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    sel_valid,
   input  logic                    cancel,
   input  logic                    refill,
   output logic                    dispense,
   output logic [SEL_W-1:0]        dispense_id,
   output logic                    change_coin,
   output logic                    coin_reject,
   output logic                    vend_err,
   output logic [CREDIT_W-1:0]     credit,
   output logic [NUM_PRODUCTS-1:0] sold_out,
   output logic                    busy
);
   localparam int EXT_W = CREDIT_W + 3;
   localparam logic [EXT_W-1:0]    MAX_EXT   = EXT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER);

   vm_state_e               state_q, state_d;
   logic [CREDIT_W-1:0]     credit_q, credit_d;
   logic [SEL_W-1:0]        id_q, id_d;
   logic                    dispense_q, change_coin_q, busy_q;
   logic                    coin_reject_q, coin_reject_d;
   logic                    vend_err_q, vend_err_d;
   logic                    coin_in, sel_in_range, sel_ok, dec;
   logic [EXT_W-1:0]        coin_sum, credit_sum;
   logic [NUM_PRODUCTS-1:0] sold_out_w;

   generate
      if ((2 ** SEL_W) == NUM_PRODUCTS) begin : g_full_sel
         assign sel_in_range = 1'b1;
      end else begin : g_part_sel
         assign sel_in_range = (sel < SEL_W'(NUM_PRODUCTS));
      end
   endgenerate

   always_comb begin
      coin_sum = '0;
      if (Q_in) coin_sum = coin_sum + EXT_W'(QUARTER);
      if (D_in) coin_sum = coin_sum + EXT_W'(DOLLAR);
   end

   assign coin_in    = Q_in | D_in;
   assign credit_sum = EXT_W'(credit_q) + coin_sum;
   assign sel_ok     = sel_in_range && !sold_out_w[sel];

   // Any sel_valid consumes the cycle, so coins with it are bounced even when the vend is refused.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      id_d          = id_q;
      dec           = 1'b0;
      vend_err_d    = 1'b0;
      coin_reject_d = 1'b0;
      unique case (state_q)
         IDLE, COLLECT: begin
            if (cancel && (credit_q != '0)) begin
               state_d       = CHANGE;
               coin_reject_d = coin_in;
            end else if (sel_valid) begin
               coin_reject_d = coin_in;
               if (sel_ok && (credit_q >= PRICE_C)) begin
                  state_d = DISPENSE;
                  id_d    = sel;
               end else begin
                  vend_err_d = 1'b1;
               end
            end else if (coin_in) begin
               if (credit_sum <= MAX_EXT) begin
                  credit_d = CREDIT_W'(credit_sum);
                  state_d  = COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         DISPENSE: begin
            dec           = 1'b1;
            credit_d      = credit_q - PRICE_C;
            state_d       = (credit_d != '0) ? CHANGE : IDLE;
            coin_reject_d = coin_in;
         end
         CHANGE: begin
            credit_d      = (credit_q >= QUARTER_C) ? (credit_q - QUARTER_C) : '0;
            state_d       = (credit_d != '0) ? CHANGE : IDLE;
            coin_reject_d = coin_in;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         id_q          <= '0;
         dispense_q    <= 1'b0;
         change_coin_q <= 1'b0;
         busy_q        <= 1'b0;
         coin_reject_q <= 1'b0;
         vend_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         id_q          <= id_d;
         dispense_q    <= (state_d == DISPENSE);
         change_coin_q <= (state_d == CHANGE);
         busy_q        <= (state_d == DISPENSE) || (state_d == CHANGE);
         coin_reject_q <= coin_reject_d;
         vend_err_q    <= vend_err_d;
      end
   end

   vm_stock_bank #(
      .NUM_PRODUCTS (NUM_PRODUCTS),
      .STOCK_INIT   (STOCK_INIT)
   ) u_stock (
      .clk        (clk),
      .rst        (rst),
      .dec_i      (dec),
      .dec_id_i   (id_q),
      .refill_i   (refill),
      .sold_out_o (sold_out_w)
   );

   assign dispense    = dispense_q;
   assign dispense_id = id_q;
   assign change_coin = change_coin_q;
   assign coin_reject = coin_reject_q;
   assign vend_err    = vend_err_q;
   assign credit      = credit_q;
   assign sold_out    = sold_out_w;
   assign busy        = busy_q;

endmodule
